cevero_mem_responder: RTL and testbench
=======================================

// Module: cevero_mem_responder
// PURPOSE
//   Memory-side responder for the core's req/gnt/rvalid instruction/data bus; the slave end of the
//   interface the core (and fault-tolerance manager) initiates on. Word-addressed single-port RAM with
//   byte enables, programmable grant wait-states and a registered one-cycle response.
//   Word 0 is the software "done" mailbox: a write to it latches done_o and exposes word 1 on result_o,
//   so benches and the SoC top detect program completion in hardware.
// PARAMETERS
//   DEPTH      1024  RAM depth in 32-bit words (power of two)
//   GNT_WAIT   0     cycles req_i must be held before gnt_o asserts (0 = same-cycle grant)
//   BASE_ADDR  32'h0 byte address of word 0
// PORTS
//   clk_i      in   1   clock
//   rst_ni     in   1   synchronous active-low reset
//   req_i      in   1   request; held by initiator until granted
//   we_i       in   1   1 = write, 0 = read
//   be_i       in   4   byte enables (write only)
//   addr_i     in   32  byte address
//   wdata_i    in   32  write data
//   gnt_o      out  1   grant; access performed on the clock edge ending this cycle
//   rvalid_o   out  1   response valid, exactly one cycle after each grant
//   rdata_o    out  32  read data (valid with rvalid_o)
//   err_o      out  1   response error (valid with rvalid_o)
//   done_o     out  1   sticky: word 0 was written with a nonzero value
//   result_o   out  32  current contents of word 1
// BEHAVIOUR
//   - Reset (rst_ni=0 at posedge): state=IDLE, wait counter=GNT_WAIT, rvalid_o=0, err_o=0,
//     rdata_o=0, done_o=0. RAM contents are NOT cleared (preloaded via $readmemb).
//   - Reset takes priority over any in-flight grant or response; no write occurs in that cycle.
//   - Index = (addr_i-BASE_ADDR)>>2; addr_i[1:0] ignored. Out of range (addr_i<BASE_ADDR or
//     index>=DEPTH) -> granted normally; write suppressed; response rdata_o=0, err_o=1.
//   - FSM IDLE/WAIT:
//       IDLE: req_i & GNT_WAIT==0 -> gnt_o=1 combinationally, stay IDLE.
//             req_i & GNT_WAIT>0  -> WAIT, counter=GNT_WAIT-1.
//       WAIT: req_i=0 -> IDLE, counter reloaded (request abandoned, no access).
//             counter!=0 -> decrement. counter==0 -> gnt_o=1, go IDLE.
//   - gnt_o is never asserted without req_i. Address, we, be and wdata are sampled only in the grant cycle.
//   - Write on grant: byte k of word updated iff be_i[k]; be_i=0 is a legal no-op write.
//   - Read on grant: rdata_o = word at the following edge, so rvalid_o=1 in cycle grant+1.
//     A write response has rvalid_o=1, rdata_o=0.
//   - rvalid_o is 1 for exactly one cycle per grant. With GNT_WAIT=0, back-to-back grants give
//     rvalid_o every cycle (full throughput).
//   - Read-after-write to the same word on consecutive grants returns the new data (no forwarding hazard,
//     since the write commits at the grant edge).
//   - done_o set at the edge of a granted in-range write to word 0 whose resulting word is nonzero;
//     stays set until reset. result_o is combinational from word 1 (reflects writes from the next cycle).
// TESTING
//   1. GNT_WAIT=0; write 32'hDEADBEEF @0x8 be=4'hF, then read 0x8 -> gnt same cycle; rvalid next
//      cycle, rdata=DEADBEEF, err=0.
//   2. Partial write be=4'b0101 data 32'h11223344 over word 0xAABBCCDD -> read returns 32'hAA22CC44.
//   3. GNT_WAIT=3; req held -> gnt in 4th cycle of req; drop req after 2 cycles -> no gnt, no rvalid,
//      memory unchanged.
//   4. Read 0x1000 with DEPTH=1024 -> rvalid with err=1, rdata=0; write there leaves RAM unchanged.
//   5. Write 32'd55 to word 1, then 1 to word 0 -> result_o=55 and done_o=1 one cycle after the
//      second grant; done_o holds until rst_ni=0.
//   6. Assert rst_ni=0 in the grant cycle of a write and in a WAIT state -> no write, rvalid_o=0 next
//      cycle, FSM IDLE, done_o=0.

Source files
------------

// File: rtl/cevero_mem_responder_if.sv
// Request/grant/response bus between an initiator (core or fault-tolerance
// manager) and the memory responder.
interface cevero_mem_responder_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/cevero_mem_responder.sv
// cevero_mem_responder: word-addressed single-port RAM on the req/gnt/rvalid
// bus with byte enables, programmable grant wait-states and a registered
// one-cycle response. Word 0 is the "done" mailbox, word 1 the result.
module cevero_mem_responder #(
  parameter int unsigned DEPTH     = 32'd1024,
  parameter int unsigned GNT_WAIT  = 32'd0,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  cevero_mem_responder_if.slave        bus,
  output logic                         done_o,
  output logic [31:0]                  result_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Wide enough to hold GNT_WAIT, and at least one bit when GNT_WAIT is 0.
  localparam int unsigned CW = $clog2(GNT_WAIT + 32'd2);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(GNT_WAIT);
  localparam logic [CW-1:0] CNT_FIRST  = CW'(GNT_WAIT - 32'd1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Replace the bytes of old_w selected by be with those of new_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    return {be[3] ? new_w[31:24] : old_w[31:24],
            be[2] ? new_w[23:16] : old_w[23:16],
            be[1] ? new_w[15:8]  : old_w[15:8],
            be[0] ? new_w[7:0]   : old_w[7:0]};
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH];

  logic              gnt_s;
  logic [29:0]       word_off_s;
  logic [1:0]        unused_byte_off_s;
  logic              in_range_s;
  logic [AW-1:0]     idx_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       wr_word_s;
  logic              mem_we_s;

  // Decode the byte address into a word index and look up / merge the word.
  always_comb begin
    {word_off_s, unused_byte_off_s} = bus.addr - BASE_ADDR;
    in_range_s = (bus.addr >= BASE_ADDR) && (word_off_s < 30'(DEPTH));
    idx_s      = word_off_s[AW-1:0];
    rd_word_s  = mem_q[idx_s];
    wr_word_s  = byte_merge(rd_word_s, bus.wdata, bus.be);
  end

  // Grant FSM: same-cycle grant when GNT_WAIT is 0, otherwise count wait-states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (GNT_WAIT == 32'd0) begin
            gnt_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_FIRST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.req) begin
          // Initiator gave up: no access, start afresh next time.
          state_d = ST_IDLE;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          gnt_s   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = CNT_RELOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_RELOAD;
      end
    endcase
  end

  // Response and mailbox next-state; the write commits at the grant edge.
  always_comb begin
    mem_we_s = gnt_s & bus.we & in_range_s;
    rvalid_d = gnt_s;
    if (gnt_s) begin
      err_d   = ~in_range_s;
      rdata_d = (!bus.we && in_range_s) ? rd_word_s : 32'h0;
    end else begin
      err_d   = 1'b0;
      rdata_d = 32'h0;
    end
    done_d = done_q | (mem_we_s & (idx_s == {AW{1'b0}}) & (|wr_word_s));
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_RELOAD;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  // RAM write port; contents survive reset, and reset blocks a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we_s) begin
      mem_q[idx_s] <= wr_word_s;
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign done_o     = done_q;
  assign result_o   = mem_q[32'd1];

endmodule

// File: tb/tb_cevero_mem_responder.sv
// Bench for cevero_mem_responder: one instance with same-cycle grant, one with
// three wait-states and a nonzero base address, checked against a word-array
// model of the memory.
module tb_cevero_mem_responder;

  logic clk;
  logic rst_ni;
  logic done0, done3;
  logic [31:0] result0, result3;

  int total = 0;
  int bad   = 0;

  cevero_mem_responder_if bus0 ();
  cevero_mem_responder_if bus3 ();

  cevero_mem_responder #(.DEPTH(32'd1024), .GNT_WAIT(32'd0), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus0), .done_o(done0), .result_o(result0));

  cevero_mem_responder #(.DEPTH(32'd1024), .GNT_WAIT(32'd3), .BASE_ADDR(32'h100)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus3), .done_o(done3), .result_o(result3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word arrays plus a sticky done flag per instance.
  logic [31:0] mdl [2][1024];
  bit          done_m [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int sel);
    return (sel == 0) ? 32'h0 : 32'h100;
  endfunction

  function automatic logic get_gnt(input int sel);
    return (sel == 0) ? bus0.gnt : bus3.gnt;
  endfunction
  function automatic logic get_rvalid(input int sel);
    return (sel == 0) ? bus0.rvalid : bus3.rvalid;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus3.rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.err : bus3.err;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : done3;
  endfunction
  function automatic logic [31:0] get_result(input int sel);
    return (sel == 0) ? result0 : result3;
  endfunction

  task automatic drive(input int sel, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.req = r; bus0.we = w; bus0.be = b; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus3.req = r; bus3.we = w; bus3.be = b; bus3.addr = a; bus3.wdata = d;
    end
  endtask

  // One complete transaction: request, wait for grant, check response and model.
  task automatic access(input int sel, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    int          cyc;
    logic        g;
    logic [31:0] off, nw, exp_rd;
    logic        inr;
    int          idx;
    @(negedge clk);
    drive(sel, 1'b1, w, b, a, d);
    cyc = 0;
    #1 g = get_gnt(sel);
    while (!g && cyc < 20) begin
      @(negedge clk);
      cyc++;
      #1 g = get_gnt(sel);
    end
    check("gnt_wait", 32'(cyc), (sel == 0) ? 32'd0 : 32'd3);
    off    = a - base_of(sel);
    inr    = (a >= base_of(sel)) && ((off >> 2) < 32'd1024);
    idx    = int'(off >> 2);
    exp_rd = 32'h0;
    if (inr) begin
      if (w) begin
        nw = mdl[sel][idx];
        for (int k = 0; k < 4; k++) if (b[k]) nw[k*8 +: 8] = d[k*8 +: 8];
        mdl[sel][idx] = nw;
        if (idx == 0 && nw != 32'h0) done_m[sel] = 1'b1;
      end else begin
        exp_rd = mdl[sel][idx];
      end
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rd = get_rdata(sel);
    check("rvalid", 32'(get_rvalid(sel)), 32'd1);
    check("rdata", rd, exp_rd);
    check("err", 32'(get_err(sel)), 32'(!inr));
    check("done", 32'(get_done(sel)), 32'(done_m[sel]));
    check("result", get_result(sel), mdl[sel][1]);
    @(posedge clk);
    #1 check("rvalid_one_cycle", 32'(get_rvalid(sel)), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          sel, idx;

    rst_ni = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    done_m[0] = 1'b0;
    done_m[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 32'(bus0.rvalid), 32'd0);
    check("rst_err", 32'(bus0.err), 32'd0);
    check("rst_rdata", bus0.rdata, 32'h0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done3", 32'(done3), 32'd0);
    check("rst_gnt", 32'(bus3.gnt), 32'd0);
    @(negedge clk) rst_ni = 1'b1;

    // Fill the test window (word 0 kept zero so done stays clear).
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        access(s, 1'b1, 4'hF, base_of(s) + 32'(i * 4), (i == 0) ? 32'h0 : $urandom, rd);
      end
    end

    // Full-word write then read back.
    access(0, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF, rd);
    access(0, 1'b0, 4'h0, 32'h8, 32'h0, rd);
    check("t1_read", rd, 32'hDEADBEEF);

    // Partial write, then a no-op write with no byte enables.
    access(0, 1'b1, 4'hF, 32'h10, 32'hAABBCCDD, rd);
    access(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, rd);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd);
    check("t2_partial", rd, 32'hAA22CC44);
    access(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, rd);
    access(0, 1'b0, 4'h0, 32'h13, 32'h0, rd);
    check("t2_be0", rd, 32'hAA22CC44);

    // Abandoned request after two wait cycles: no grant, no response, no write.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h108, 32'h0BAD0BAD);
    #1 check("abandon_gnt_c1", 32'(bus3.gnt), 32'd0);
    @(negedge clk);
    #1 check("abandon_gnt_c2", 32'(bus3.gnt), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("abandon_rvalid", 32'(bus3.rvalid), 32'd0);
    end
    access(1, 1'b0, 4'h0, 32'h108, 32'h0, rd);

    // Out-of-range accesses, including one aliasing word 0 and one below base.
    access(0, 1'b0, 4'h0, 32'h1000, 32'h0, rd);
    check("t4_oor_rdata", rd, 32'h0);
    access(0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, rd);
    access(0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
    access(1, 1'b1, 4'hF, 32'h0, 32'h12345678, rd);
    access(1, 1'b0, 4'h0, 32'h100, 32'h0, rd);

    // Back-to-back grants with a read-after-write to the same word.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    #1 check("b2b_gnt1", 32'(bus0.gnt), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_rv1", 32'(bus0.rvalid), 32'd1);
    check("b2b_rd1", bus0.rdata, mdl[0][2]);
    drive(0, 1'b1, 1'b1, 4'hF, 32'hC, 32'h87654321);
    #1 check("b2b_gnt2", 32'(bus0.gnt), 32'd1);
    @(posedge clk);
    #1;
    mdl[0][3] = 32'h87654321;
    check("b2b_rv2", 32'(bus0.rvalid), 32'd1);
    check("b2b_rd2", bus0.rdata, 32'h0);
    drive(0, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
    @(posedge clk);
    #1;
    check("b2b_rv3", 32'(bus0.rvalid), 32'd1);
    check("b2b_raw", bus0.rdata, 32'h87654321);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 check("b2b_rv_end", 32'(bus0.rvalid), 32'd0);

    // Mailbox: result in word 1, then nonzero write to word 0 raises done.
    access(0, 1'b1, 4'hF, 32'h4, 32'd55, rd);
    check("t5_done_before", 32'(done0), 32'd0);
    access(0, 1'b1, 4'hF, 32'h0, 32'd1, rd);
    check("t5_result", result0, 32'd55);
    check("t5_done", 32'(done0), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("t5_done_hold", 32'(done0), 32'd1);

    // Randomised traffic on both instances.
    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      a   = base_of(sel) + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        if (sel == 1 && $urandom_range(0, 1) == 1) a = 32'(idx * 4);
        else a = base_of(sel) + 32'h1000 + 32'(idx * 4);
      end
      access(sel, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, rd);
    end

    // Reset during a write's grant cycle and during a wait-state.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h114, 32'h5A5A5A5A);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'hF, 32'h14, 32'hA5A5A5A5);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    done_m[0] = 1'b0;
    done_m[1] = 1'b0;
    check("t6_rvalid0", 32'(bus0.rvalid), 32'd0);
    check("t6_rvalid3", 32'(bus3.rvalid), 32'd0);
    check("t6_done0", 32'(done0), 32'd0);
    check("t6_done3", 32'(done3), 32'd0);
    @(negedge clk) rst_ni = 1'b1;
    access(0, 1'b0, 4'h0, 32'h14, 32'h0, rd);
    access(1, 1'b0, 4'h0, 32'h114, 32'h0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
